i2c_reg_master: RTL
===================

Name: i2c_reg_master

Overview:
- Single-master I2C controller that performs one register-access transaction per request: an 8-bit register write, or an 8-bit register read using a repeated START.
- Drives open-drain SCL/SDA. It is the initiator side for I2C peripherals in the core, such as the PCF8583-style RTC at 7-bit address 0x50, and is used by bench models and host-side glue.
- Exposes a simple req/busy/done handshake to the system side.

Parameters:
- CLOCK_RATE, 32000000, clk frequency in Hz.
- BUS_RATE, 100000, SCL frequency in Hz. Quarter-bit period Q = CLOCK_RATE/(4*BUS_RATE) clocks, integer division, minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  1  one-cycle transaction request; sampled only in IDLE
- rw  in  1  0 = write, 1 = read; latched with req
- dev_addr  in  7  7-bit slave address; latched with req
- reg_addr  in  8  register pointer byte; latched with req
- wdata  in  8  write data byte; latched with req
- rdata  out  8  byte read from slave; valid when done=1 and rw=1
- busy  out  1  high from the cycle after req until the cycle done pulses
- done  out  1  one-cycle pulse at transaction end
- nack  out  1  status of the last transaction, valid with done: 1 = a slave NACK was seen
- scl_i  in  1  SCL line level, already synchronised
- sda_i  in  1  SDA line level, already synchronised
- scl_o  out  1  0 = pull SCL low, 1 = release
- sda_o  out  1  0 = pull SDA low, 1 = release

Behaviour:
- Reset values: scl_o=1, sda_o=1, busy=0, done=0, nack=0, rdata=0; state=IDLE; quarter counter=0.
- Reset mid-transaction: both lines are released on the next clk. No STOP is generated.
- Timing: a quarter counter produces a tick every Q clocks while busy. Each bit is 4 quarters:
  - q0: SCL low; SDA is updated here only.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL high.
- Clock stretching: the counter is frozen in q2 while scl_i=0 after release, and resumes on the first clock where scl_i=1.
- SDA sampling: at the end of q3.
- Bit order: MSB first.
- States: IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, MACK, STOP. ACK slots are handled inside each byte state as bit 9; SDA is released during that bit.
- IDLE -> START on req. The cycle after req: inputs latched, busy=1.
- START: SDA falls while SCL is high; SCL is then pulled low.
- Write sequence: START, ADDR_W ({dev_addr,0}), REG, WDATA, STOP.
- Read sequence: START, ADDR_W, REG, RSTART, ADDR_R ({dev_addr,1}), RDATA, MACK (SDA released = NACK), STOP.
- RSTART: SDA is released while SCL is low, SCL is released, then SDA falls while SCL is high.
- Slave ACK: sampled SDA=0 is ACK. Sampled SDA=1 sets nack=1 and the sequence jumps directly to STOP; no further bytes are sent.
- STOP: SDA low, SCL released, then SDA released while SCL is high. One quarter later: done=1 for one clk, busy=0, return to IDLE.
- nack is cleared when a new req is accepted.
- rdata updates only at the end of a successful RDATA byte. It holds its value otherwise.
- req while busy is ignored and not queued. req in the same cycle as done is also ignored.
- No arbitration and no multi-master support; sda_i is not compared against sda_o except at ACK and read bits.
- SDA never changes while SCL is high, except for START, RSTART and STOP conditions.

Test Plan:
- Write, CLOCK_RATE=32000000, BUS_RATE=100000 (Q=80), slave model at 0x50: dev_addr=0x50, reg_addr=0x02, wdata=0x45 -> bytes 0xA0, 0x02, 0x45 on the bus, each ACKed; STOP; done pulse; nack=0; bit period = 320 clks.
- Read, same slave, slave returns 0x93 for reg 0x04: -> bytes 0xA0, 0x04, then repeated START, then 0xA1, then 0x93 clocked in; master NACKs; STOP; rdata=0x93; nack=0.
- Absent address: dev_addr=0x51 with only 0x50 present -> NACK on first byte, immediate STOP, exactly 9 SCL pulses total, done with nack=1, rdata unchanged.
- Clock stretch: slave holds SCL low 500 clks after the ACK of the register byte -> that SCL high phase starts 500 clks late, remaining timing nominal, data correct.
- Reset mid-byte: assert reset during bit 3 of REG -> scl_o=1, sda_o=1, busy=0 on the next clk. A following req completes normally.
- req pulse while busy with different dev_addr -> ignored; bus shows only the first transaction; exactly one done pulse.

Source files
------------

// File: rtl/i2c_reg_master.sv
// Single-master I2C register-access controller: one 8-bit register write or
// one 8-bit register read (with repeated START) per request, open-drain SCL/SDA.
module i2c_reg_master #(
  parameter int CLOCK_RATE = 32000000,
  parameter int BUS_RATE   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  // Quarter-bit period in clk cycles, never below one.
  localparam int QRAW = CLOCK_RATE / (4 * BUS_RATE);
  localparam int Q    = (QRAW < 1) ? 1 : QRAW;
  localparam int CW   = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, MACK, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          stretch, tick, lastBit;
  logic [7:0]    txByte;

  // A slave holding SCL low after we release it in q2 freezes the quarter counter.
  assign stretch = (qtr_q == 2'd2) && !scl_i;
  assign tick    = (state_q != IDLE) && !stretch && (cnt_q == CW'(Q - 1));

  // Identify the final bit of the current state (ACK slot for transmitted bytes).
  always_comb begin
    case (state_q)
      RDATA:                      lastBit = (bit_q == 4'd7);
      ADDR_W, REG, WDATA, ADDR_R: lastBit = (bit_q == 4'd8);
      default:                    lastBit = 1'b1;
    endcase
  end

  // Next-state, sequencing and line-level decode; lines are decoded from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    rw_d    = rw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    txByte  = 8'hFF;
    scl_d   = 1'b1;
    sda_d   = 1'b1;

    if (state_q == IDLE) begin
      cnt_d = '0;
      qtr_d = 2'd0;
      bit_d = 4'd0;
      if (req && !done_q) begin
        state_d = START;
        rw_d    = rw;
        dev_d   = dev_addr;
        reg_d   = reg_addr;
        wdata_d = wdata;
        nack_d  = 1'b0;
      end
    end else if (!tick) begin
      if (!stretch) cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      qtr_d = qtr_q + 1'b1;
      if (qtr_q == 2'd3) begin
        bit_d = lastBit ? 4'd0 : bit_q + 1'b1;
        case (state_q)
          START:  state_d = ADDR_W;
          RSTART: state_d = ADDR_R;
          ADDR_W, REG, WDATA, ADDR_R: begin
            if (lastBit) begin
              if (sda_i) begin
                nack_d  = 1'b1;
                state_d = STOP;
              end else begin
                case (state_q)
                  ADDR_W:  state_d = REG;
                  REG:     state_d = rw_q ? RSTART : WDATA;
                  WDATA:   state_d = STOP;
                  default: state_d = RDATA;
                endcase
              end
            end
          end
          RDATA: begin
            shift_d = {shift_q[5:0], sda_i};
            if (lastBit) begin
              rdata_d = {shift_q, sda_i};
              state_d = MACK;
            end
          end
          MACK: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    busy_d = (state_d != IDLE);

    case (state_d)
      ADDR_W:  txByte = {dev_d, 1'b0};
      REG:     txByte = reg_d;
      WDATA:   txByte = wdata_d;
      ADDR_R:  txByte = {dev_d, 1'b1};
      default: txByte = 8'hFF;
    endcase

    case (state_d)
      START: sda_d = (qtr_d < 2'd2);
      RSTART: begin
        scl_d = qtr_d[1];
        sda_d = (qtr_d != 2'd3);
      end
      STOP: begin
        scl_d = qtr_d[1];
        sda_d = (qtr_d == 2'd3);
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        scl_d = qtr_d[1];
        sda_d = bit_d[3] ? 1'b1 : txByte[3'd7 - bit_d[2:0]];
      end
      RDATA, MACK: scl_d = qtr_d[1];
      default: ;
    endcase
  end

  // State and datapath registers; reset releases both lines immediately without a STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 4'd0;
      rw_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wdata_q <= 8'd0;
      shift_q <= 7'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign nack  = nack_q;
  assign scl_o = scl_q;
  assign sda_o = sda_q;

endmodule
